text_buffer_writer: RTL and testbench
=====================================

Name: text_buffer_writer

Overview:
- Character-stream writer for the VGA text display: accepts character codes over a valid/ready stream and places them into an internal ROWS x COLS character buffer.
- Manages a cursor with control-code handling, line wrap and scrolling.
- Exposes a registered read port from which the glyph renderer fetches the character code for the cell under the beam.
- Sits between the character source (UART/console logic) and the font-ROM renderer, all in the vga_clk domain.

Parameters:
COLS, 40, characters per row (640 px / 16 px glyph)
ROWS, 15, character rows (480 px / 32 px glyph)
BLANK, 8'h20, fill code used for cleared cells

Ports:
vga_clk  input  1  pixel clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_valid  input  1  in_char is valid this cycle
in_ready  output  1  writer can accept a character this cycle
in_char  input  8  character code (ASCII/KOI8 glyph index)
rd_col  input  6  renderer cell column
rd_row  input  4  renderer cell row (logical, 0 = top of screen)
rd_char  output  8  code stored at (rd_row, rd_col), registered
cursor_col  output  6  current cursor column
cursor_row  output  4  current cursor row (logical)
busy  output  1  high while a clear operation is in progress

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is synchronous and active-low on reset_n.
- Reset values: in_ready=0, busy=1, cursor_col=0, cursor_row=0, rd_char=BLANK, top row offset=0, state=CLR_ALL, clear index=0.
- State machine: CLR_ALL, IDLE, CLR_LINE. in_ready = (state==IDLE); busy = !in_ready.
- CLR_ALL: writes BLANK to one cell per cycle, ROWS*COLS cycles (600 at defaults), then goes to IDLE. in_ready rises on cycle 600 after reset release.
- Accept: a character is consumed when in_valid && in_ready. At most one per cycle. The effect is visible on the read port from the next cycle.
- Printable (in_char >= 8'h20): write in_char at the cursor cell, then advance the cursor.
  - col<COLS-1: col+1.
  - col==COLS-1: col=0 and perform row advance (wrap).
- 8'h0A (LF): col=0, row advance.
- 8'h0D (CR): col=0, row unchanged.
- 8'h08 (BS):
  - col>0: col-1 and write BLANK at the new cursor cell.
  - col==0: no effect (no reverse wrap).
- 8'h0C (FF): cursor=(0,0), top offset=0, go to CLR_ALL (600 cycles).
- Any other code < 8'h20: accepted, no effect.
- Row advance:
  - row<ROWS-1: row+1.
  - row==ROWS-1: row stays ROWS-1, top offset=(top+1) mod ROWS, and go to CLR_LINE. CLR_LINE writes BLANK to the COLS cells of the new bottom physical row, one per cycle (40 cycles), then returns to IDLE.
- Addressing: physical row = (logical row + top) mod ROWS. Both operands are < ROWS, so compute it as a single conditional subtract, no divider. Cell address = phys_row*COLS + col.
- Read port:
  - rd_char is registered, 1-cycle latency from rd_col/rd_row.
  - rd_col>=COLS or rd_row>=ROWS returns BLANK.
  - Read and write to the same cell in the same cycle return the old value.
  - Reads are served in every state; cells being cleared may show stale or BLANK content.
- Storage: one write port, one read port; must infer block RAM (no reset of array contents; clearing is done by the state machine).
- Reset mid-operation (any state, including CLR_LINE): all registers return to reset values and CLR_ALL restarts from index 0.
- in_valid while in_ready=0: character not consumed; the source must hold it.

Test Plan:
- Release reset -> in_ready low for exactly 600 cycles then high. Every (row,col) in range reads 8'h20; rd_row=15 reads 8'h20.
- Send "Hi" (8'h48, 8'h69) back-to-back -> accepted on 2 consecutive cycles. Read (0,0)=8'h48, (0,1)=8'h69; cursor=(row 0, col 2).
- Send 41 'A' (8'h41) -> row 0 cols 0..39 = 8'h41, (1,0)=8'h41, cursor=(1,1).
- Write 'X' on row 0, then 14 LFs plus one more LF -> in_ready low for 40 cycles after the 15th LF. Logical row 13 holds what was row 14, row 14 is all 8'h20, 'X' is gone from logical row 0 (now shows former row 1), cursor=(14,0).
- At col 0 send BS -> no change, cursor (r,0). Send "ab" then BS -> (r,1)=8'h20, cursor col 1.
- Send FF with cursor at (7,12), and separately assert reset_n=0 for 1 cycle in mid-CLR_LINE -> in_ready low 600 cycles, whole screen 8'h20, cursor=(0,0).

Source files
------------

// File: rtl/text_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer_writer
// Purpose  : Character-stream writer for the VGA text display. Accepts
//            character codes on a valid/ready stream, places them into a
//            ROWS x COLS character buffer, tracks a cursor (CR/LF/BS/FF,
//            line wrap, scrolling) and serves a registered read port to the
//            glyph renderer. All logic runs in the vga_clk domain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   vga_clk     in   1  pixel clock, all logic on the rising edge
//   reset_n     in   1  synchronous active-low reset
//   in_valid    in   1  in_char is valid this cycle
//   in_ready    out  1  writer accepts a character this cycle
//   in_char     in   8  character code (glyph index)
//   rd_col      in   6  renderer cell column
//   rd_row      in   4  renderer cell row (logical, 0 = top of screen)
//   rd_char     out  8  code stored at (rd_row, rd_col), one cycle latency
//   cursor_col  out  6  current cursor column
//   cursor_row  out  4  current cursor row (logical)
//   busy        out  1  high while a clear operation is in progress
// ============================================================================
module text_buffer_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 15,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [5:0] rd_col,
    input  logic [3:0] rd_row,
    output logic [7:0] rd_char,
    output logic [5:0] cursor_col,
    output logic [3:0] cursor_row,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int              c_DEPTH        = ROWS * COLS;
    localparam int              c_AW           = $clog2(c_DEPTH);
    localparam logic [c_AW-1:0] c_DEPTH_LAST   = c_AW'(c_DEPTH - 1);
    localparam logic [c_AW-1:0] c_COLS_LAST_AW = c_AW'(COLS - 1);
    localparam logic [c_AW-1:0] c_COLS_AW      = c_AW'(COLS);
    localparam logic [5:0]      c_COLS_LAST    = 6'(COLS - 1);
    localparam logic [6:0]      c_COLS_W       = 7'(COLS);
    localparam logic [3:0]      c_ROWS_LAST    = 4'(ROWS - 1);
    localparam logic [4:0]      c_ROWS_W       = 5'(ROWS);

    localparam logic [7:0] c_CH_BS    = 8'h08;
    localparam logic [7:0] c_CH_LF    = 8'h0A;
    localparam logic [7:0] c_CH_FF    = 8'h0C;
    localparam logic [7:0] c_CH_CR    = 8'h0D;
    localparam logic [7:0] c_CH_PRINT = 8'h20;

    typedef enum logic [1:0] {
        S_CLR_ALL  = 2'd0,
        S_IDLE     = 2'd1,
        S_CLR_LINE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Logical-to-physical row rotation. Both operands are below ROWS, so the
    // sum is below 2*ROWS and one conditional subtract replaces a modulo.
    function automatic logic [3:0] phys_row(input logic [3:0] lrow,
                                            input logic [3:0] top);
        logic [4:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= c_ROWS_W) begin
            return 4'(sum - c_ROWS_W);
        end
        return 4'(sum);
    endfunction

    function automatic logic [c_AW-1:0] cell_addr(input logic [3:0] prow,
                                                  input logic [5:0] col);
        return c_AW'(prow) * c_COLS_AW + c_AW'(col);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          r_state_q, r_state_d;
    logic [5:0]      r_col_q,   r_col_d;
    logic [3:0]      r_row_q,   r_row_d;
    logic [3:0]      r_top_q,   r_top_d;
    logic [c_AW-1:0] r_idx_q,   r_idx_d;
    logic [7:0]      r_rd_char_q;

    // Character storage: one write port, one registered read port, no reset
    // so that it maps onto block RAM. Clearing is done by the state machine.
    logic [7:0]      r_mem [0:c_DEPTH-1];

    logic            w_we;
    logic [c_AW-1:0] w_waddr;
    logic [7:0]      w_wdata;
    logic            w_accept;
    logic            w_row_adv;
    logic [3:0]      w_cur_prow;
    logic [3:0]      w_bot_prow;
    logic [3:0]      w_rd_prow;
    logic            w_rd_in_range;
    logic [c_AW-1:0] w_rd_addr;

    assign in_ready   = (r_state_q == S_IDLE);
    assign busy       = ~in_ready;
    assign cursor_col = r_col_q;
    assign cursor_row = r_row_q;
    assign rd_char    = r_rd_char_q;

    assign w_accept   = in_valid & in_ready;
    assign w_cur_prow = phys_row(r_row_q, r_top_q);
    // During CLR_LINE the top offset has already moved, so logical row
    // ROWS-1 names the freshly exposed bottom physical row.
    assign w_bot_prow = phys_row(c_ROWS_LAST, r_top_q);

    // ------------------------------------------------------------------------
    // Next-state, cursor and write-port logic
    // ------------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        r_col_d   = r_col_q;
        r_row_d   = r_row_q;
        r_top_d   = r_top_q;
        r_idx_d   = r_idx_q;
        w_we      = 1'b0;
        w_waddr   = cell_addr(w_cur_prow, r_col_q);
        w_wdata   = BLANK;
        w_row_adv = 1'b0;

        case (r_state_q)
            S_CLR_ALL: begin
                w_we    = 1'b1;
                w_waddr = r_idx_q;
                if (r_idx_q == c_DEPTH_LAST) begin
                    r_idx_d   = '0;
                    r_state_d = S_IDLE;
                end else begin
                    r_idx_d = r_idx_q + 1'b1;
                end
            end

            S_CLR_LINE: begin
                w_we    = 1'b1;
                w_waddr = cell_addr(w_bot_prow, 6'd0) + r_idx_q;
                if (r_idx_q == c_COLS_LAST_AW) begin
                    r_idx_d   = '0;
                    r_state_d = S_IDLE;
                end else begin
                    r_idx_d = r_idx_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (w_accept) begin
                    if (in_char >= c_CH_PRINT) begin
                        // Written with the current top offset; a wrap that
                        // scrolls only takes effect from the next cycle.
                        w_we    = 1'b1;
                        w_wdata = in_char;
                        if (r_col_q == c_COLS_LAST) begin
                            r_col_d   = 6'd0;
                            w_row_adv = 1'b1;
                        end else begin
                            r_col_d = r_col_q + 6'd1;
                        end
                    end else begin
                        case (in_char)
                            c_CH_LF: begin
                                r_col_d   = 6'd0;
                                w_row_adv = 1'b1;
                            end
                            c_CH_CR: begin
                                r_col_d = 6'd0;
                            end
                            c_CH_BS: begin
                                // No reverse wrap from column 0.
                                if (r_col_q != 6'd0) begin
                                    r_col_d = r_col_q - 6'd1;
                                    w_we    = 1'b1;
                                    w_waddr = cell_addr(w_cur_prow,
                                                        r_col_q - 6'd1);
                                end
                            end
                            c_CH_FF: begin
                                r_col_d   = 6'd0;
                                r_row_d   = 4'd0;
                                r_top_d   = 4'd0;
                                r_idx_d   = '0;
                                r_state_d = S_CLR_ALL;
                            end
                            default: begin
                                // Other control codes are swallowed.
                            end
                        endcase
                    end

                    if (w_row_adv) begin
                        if (r_row_q != c_ROWS_LAST) begin
                            r_row_d = r_row_q + 4'd1;
                        end else begin
                            // Scroll: rotate the ring by one row and blank
                            // the row that becomes the new bottom line.
                            r_top_d   = (r_top_q == c_ROWS_LAST) ? 4'd0
                                                                 : r_top_q + 4'd1;
                            r_idx_d   = '0;
                            r_state_d = S_CLR_LINE;
                        end
                    end
                end
            end

            default: begin
                r_idx_d   = '0;
                r_state_d = S_CLR_ALL;
            end
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state_q <= S_CLR_ALL;
            r_col_q   <= 6'd0;
            r_row_q   <= 4'd0;
            r_top_q   <= 4'd0;
            r_idx_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_col_q   <= r_col_d;
            r_row_q   <= r_row_d;
            r_top_q   <= r_top_d;
            r_idx_q   <= r_idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage and read port
    // ------------------------------------------------------------------------
    assign w_rd_in_range = ({1'b0, rd_col} < c_COLS_W) && ({1'b0, rd_row} < c_ROWS_W);
    assign w_rd_prow     = phys_row(rd_row, r_top_q);
    assign w_rd_addr     = w_rd_in_range ? cell_addr(w_rd_prow, rd_col) : '0;

    always_ff @(posedge vga_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Kept as a direct array read in a clocked block so the output register
    // folds into the RAM; a same-cycle write to the same cell returns the
    // old contents.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rd_char_q <= BLANK;
        end else if (w_rd_in_range) begin
            r_rd_char_q <= r_mem[w_rd_addr];
        end else begin
            r_rd_char_q <= BLANK;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_buffer_writer
// Purpose  : Directed self-checking bench for text_buffer_writer: reset
//            clear, printable writes, wrap, scroll, backspace, form feed and
//            reset in the middle of a line clear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_buffer_writer;

    logic       vga_clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [5:0] rd_col;
    logic [3:0] rd_row;
    logic [7:0] rd_char;
    logic [5:0] cursor_col;
    logic [3:0] cursor_row;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    text_buffer_writer #(
        .COLS  (40),
        .ROWS  (15),
        .BLANK (8'h20)
    ) u_dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_char    (rd_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Present a character and hold it until it is consumed.
    task automatic send(input logic [7:0] ch);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_char  = ch;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check_eq("send_timeout", n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        rd_row = 4'(r);
        rd_col = 6'(c);
        tick();
        v = rd_char;
    endtask

    task automatic count_cells(input int r0, input int r1, input int c0,
                               input int c1, input logic [7:0] val,
                               output int nbad);
        logic [7:0] v;
        nbad = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                read_cell(r, c, v);
                if (v !== val) nbad++;
            end
        end
    endtask

    initial begin
        int         n;
        logic [7:0] v;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        rd_row   = 4'd0;
        rd_col   = 6'd0;
        repeat (3) tick();

        // ---------------- reset state and initial clear ----------------
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_cursor_col", cursor_col, 6'd0);
        check_eq("rst_cursor_row", cursor_row, 4'd0);
        check_eq("rst_rd_char", rd_char, 8'h20);

        reset_n = 1'b1;
        wait_ready(n);
        check_eq("clr_all_cycles", n, 600);
        check_eq("ready_busy_low", busy, 1'b0);
        count_cells(0, 14, 0, 39, 8'h20, n);
        check_eq("clr_all_blank_cells_bad", n, 0);
        read_cell(15, 0, v);
        check_eq("rd_row15_blank", v, 8'h20);

        // ---------------- "Hi" back-to-back ----------------
        send(8'h48);
        check_eq("hi_first_col", cursor_col, 6'd1);
        send(8'h69);
        check_eq("hi_second_col", cursor_col, 6'd2);
        check_eq("hi_row", cursor_row, 4'd0);
        read_cell(0, 0, v);
        check_eq("hi_cell00", v, 8'h48);
        read_cell(0, 1, v);
        check_eq("hi_cell01", v, 8'h69);

        // ---------------- 41 'A' with wrap ----------------
        send(8'h0D);
        check_eq("cr_col", cursor_col, 6'd0);
        for (int i = 0; i < 41; i++) send(8'h41);
        check_eq("wrap_cursor_row", cursor_row, 4'd1);
        check_eq("wrap_cursor_col", cursor_col, 6'd1);
        count_cells(0, 0, 0, 39, 8'h41, n);
        check_eq("wrap_row0_bad", n, 0);
        read_cell(1, 0, v);
        check_eq("wrap_cell10", v, 8'h41);
        read_cell(1, 1, v);
        check_eq("wrap_cell11", v, 8'h20);
        read_cell(0, 40, v);
        check_eq("rd_col40_blank", v, 8'h20);
        read_cell(15, 0, v);
        check_eq("rd_row15_blank_after_write", v, 8'h20);

        // ---------------- scroll ----------------
        send(8'h0C);
        wait_ready(n);
        check_eq("ff_clear_cycles", n, 600);
        send(8'h58);
        for (int i = 1; i <= 14; i++) begin
            send(8'h0A);
            send(8'(8'h30 + i));
        end
        check_eq("pre_scroll_row", cursor_row, 4'd14);
        send(8'h0A);
        wait_ready(n);
        check_eq("clr_line_cycles", n, 40);
        read_cell(0, 0, v);
        check_eq("scroll_row0", v, 8'h31);
        read_cell(12, 0, v);
        check_eq("scroll_row12", v, 8'h3D);
        read_cell(13, 0, v);
        check_eq("scroll_row13", v, 8'h3E);
        count_cells(14, 14, 0, 39, 8'h20, n);
        check_eq("scroll_row14_bad", n, 0);
        check_eq("scroll_cursor_row", cursor_row, 4'd14);
        check_eq("scroll_cursor_col", cursor_col, 6'd0);
        send(8'h5A);
        read_cell(14, 0, v);
        check_eq("bottom_write", v, 8'h5A);
        read_cell(0, 0, v);
        check_eq("bottom_write_row0_intact", v, 8'h31);

        // ---------------- backspace ----------------
        send(8'h0D);
        send(8'h08);
        check_eq("bs_col0_col", cursor_col, 6'd0);
        check_eq("bs_col0_row", cursor_row, 4'd14);
        read_cell(14, 0, v);
        check_eq("bs_col0_cell", v, 8'h5A);
        send(8'h61);
        send(8'h62);
        send(8'h08);
        check_eq("bs_cursor_col", cursor_col, 6'd1);
        read_cell(14, 1, v);
        check_eq("bs_erased", v, 8'h20);
        read_cell(14, 0, v);
        check_eq("bs_kept", v, 8'h61);
        send(8'h07);
        check_eq("ctrl_ignored_col", cursor_col, 6'd1);
        check_eq("ctrl_ignored_ready", in_ready, 1'b1);

        // ---------------- form feed from (7,12) ----------------
        send(8'h0C);
        wait_ready(n);
        for (int i = 0; i < 7; i++) send(8'h0A);
        for (int i = 0; i < 12; i++) send(8'h71);
        check_eq("ff_pre_row", cursor_row, 4'd7);
        check_eq("ff_pre_col", cursor_col, 6'd12);
        send(8'h0C);
        check_eq("ff_cursor_col", cursor_col, 6'd0);
        check_eq("ff_cursor_row", cursor_row, 4'd0);
        wait_ready(n);
        check_eq("ff_cycles", n, 600);
        count_cells(0, 14, 0, 39, 8'h20, n);
        check_eq("ff_blank_bad", n, 0);

        // ---------------- reset during CLR_LINE ----------------
        send(8'h6B);
        for (int i = 0; i < 15; i++) send(8'h0A);
        repeat (10) tick();
        check_eq("mid_clr_line_busy", busy, 1'b1);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_cursor_row", cursor_row, 4'd0);
        reset_n = 1'b1;
        wait_ready(n);
        check_eq("mid_rst_clear_cycles", n, 600);
        check_eq("mid_rst_cursor_col", cursor_col, 6'd0);
        count_cells(0, 14, 0, 39, 8'h20, n);
        check_eq("mid_rst_blank_bad", n, 0);

        // ---------------- character held while not ready ----------------
        send(8'h0C);
        in_valid = 1'b1;
        in_char  = 8'h51;
        wait_ready(n);
        check_eq("held_wait_cycles", n, 600);
        check_eq("held_not_consumed", cursor_col, 6'd0);
        tick();
        in_valid = 1'b0;
        check_eq("held_consumed_col", cursor_col, 6'd1);
        read_cell(0, 0, v);
        check_eq("held_cell00", v, 8'h51);
        read_cell(0, 1, v);
        check_eq("held_cell01", v, 8'h20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
